// File: rtl/fp_round_normalize.sv
// fp_round_normalize: final round/normalise stage of the FP64 adder, 2-stage valid/ready pipeline.
//   in_*  : sign, signed biased exponent, 56-bit corrected mantissa {hidden,frac[51:0],G,R,S},
//           second_shift_left flag, rounding mode (00 RNE, 01 RTZ, 10 RUP, 11 RDN)
//   out_* : packed IEEE double and {overflow, underflow, inexact}
//   FP_ROUND_STICKY_FLAGS_EN : when defined, sticky_flags accumulates out_flags (flag_clr clears);
//                              otherwise sticky_flags is 0 and flag_clr is ignored.
module fp_round_normalize #(
  parameter int EXP_W  = 12,
  parameter int MANT_W = 56
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_second_shift,
  input  logic [1:0]        in_rm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_result,
  output logic [2:0]        out_flags,
  input  logic              flag_clr,
  output logic [2:0]        sticky_flags
);
  localparam logic [EXP_W:0] E_MAX = (EXP_W+1)'(2047);
  logic                s1_valid_q, s1_sign_q, s1_inc_q, s1_inex_q, s1_zero_q;
  logic [EXP_W-1:0]    s1_exp_q;
  logic [MANT_W-4:0]   s1_mant_q;
  logic [1:0]          s1_rm_q;
  logic                s2_valid_q;
  logic [63:0]         out_result_q;
  logic [2:0]          out_flags_q;
  logic                s1_adv, s2_adv, grs, inc_d, le0, ovf, to_inf, unused_m;
  logic [EXP_W-1:0]    e1_d;
  logic [MANT_W-3:0]   m;
  logic [EXP_W:0]      e2;
  logic [51:0]         frac;
  logic [63:0]         result_d;
  logic [2:0]          flags_d;
  assign s2_adv     = ~s2_valid_q | out_ready;
  assign s1_adv     = ~s1_valid_q | s2_adv;
  assign in_ready   = s1_adv;
  assign out_valid  = s2_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign grs        = |in_mant[2:0];
  always_comb begin
    e1_d  = in_exp - EXP_W'(in_second_shift);
    inc_d = in_rm == 2'b00 ? in_mant[2] & (in_mant[1] | in_mant[0] | in_mant[3]) :
            in_rm == 2'b01 ? 1'b0 :
            in_rm == 2'b10 ? ~in_sign & grs : in_sign & grs;
  end
  // e2 carries one extra bit so a carry out of exponent 2047 still reads as overflow
  always_comb begin
    m        = {1'b0, s1_mant_q} + (MANT_W-2)'(s1_inc_q);
    e2       = {s1_exp_q[EXP_W-1], s1_exp_q} + (EXP_W+1)'(m[MANT_W-3]);
    le0      = e2[EXP_W] | ~|e2;
    ovf      = ~e2[EXP_W] & (e2 >= E_MAX);
    to_inf   = s1_rm_q == 2'b00 | (s1_rm_q == 2'b10 & ~s1_sign_q) | (s1_rm_q == 2'b11 & s1_sign_q);
    frac     = m[MANT_W-3] ? 52'b0 : m[51:0];
    unused_m = m[MANT_W-4];
    result_d = s1_zero_q | le0 ? {s1_sign_q, 63'b0} :
               ovf ? (to_inf ? {s1_sign_q, 11'h7FF, 52'b0} : {s1_sign_q, 11'h7FE, {52{1'b1}}}) :
               {s1_sign_q, e2[10:0], frac};
    flags_d  = s1_zero_q ? 3'b000 : le0 ? 3'b011 : ovf ? 3'b101 : {2'b00, s1_inex_q};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        s1_sign_q  <= in_sign;
        s1_exp_q   <= e1_d;
        s1_mant_q  <= in_mant[MANT_W-1:3];
        s1_inc_q   <= inc_d;
        s1_inex_q  <= grs;
        s1_zero_q  <= ~|in_mant;
        s1_rm_q    <= in_rm;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_result_q <= result_d;
          out_flags_q  <= flags_d;
        end
      end
    end
  end
`ifdef FP_ROUND_STICKY_FLAGS_EN
  logic [2:0] sticky_q;
  // a clear on a transfer cycle drops that transfer's flags
  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= '0;
    else sticky_q <= flag_clr ? 3'b0 : sticky_q | (out_valid & out_ready ? out_flags_q : 3'b0);
  end
  assign sticky_flags = sticky_q;
`else
  logic unused_clr;
  assign unused_clr   = flag_clr;
  assign sticky_flags = 3'b0;
`endif
endmodule

// File: tb/tb_fp_round_normalize.sv
module tb_fp_round_normalize;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_sign = 0, in_second_shift = 0;
  logic        out_ready = 0, flag_clr = 0, in_ready, out_valid;
  logic [11:0] in_exp = '0;
  logic [55:0] in_mant = '0;
  logic [1:0]  in_rm = '0;
  logic [63:0] out_result;
  logic [2:0]  out_flags, sticky_flags;
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [66:0] exp_q[$];
  int          acc_q[$];
  logic [2:0]  sticky_m = '0;

  fp_round_normalize dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_mant(in_mant), .in_second_shift(in_second_shift), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .flag_clr(flag_clr), .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: IEEE rounding of the 53-bit significand with a 3-bit GRS tail, done with integers.
  function automatic logic [66:0] ref_model(input bit s, input logic [11:0] e, input logic [55:0] mn,
                                            input bit ssl, input logic [1:0] rm);
    int ex, rem;
    longint q;
    bit up, inf;
    logic [51:0] fr;
    if (mn == 0) return {3'b000, s, 63'b0};
    ex  = int'($signed(e)) - int'(ssl);
    q   = longint'(mn >> 3);
    rem = int'(mn[2:0]);
    case (rm)
      2'd0: up = rem > 4 || (rem == 4 && q[0]);
      2'd1: up = 0;
      2'd2: up = rem != 0 && !s;
      default: up = rem != 0 && s;
    endcase
    q = q + longint'(up);
    if (q >= (longint'(1) << 53)) begin
      ex++;
      q = q >> 1;
    end
    fr = q[51:0];
    if (ex <= 0) return {3'b011, s, 63'b0};
    if (ex >= 2047) begin
      inf = rm == 0 || (rm == 2 && !s) || (rm == 3 && s);
      return {3'b101, inf ? {s, 11'h7FF, 52'b0} : {s, 11'h7FE, {52{1'b1}}}};
    end
    return {2'b00, rem != 0, s, ex[10:0], fr};
  endfunction

  function automatic bit model_ov();
    return exp_q.size() > 0 && cyc > acc_q[0];
  endfunction

  task automatic check_out();
    chk("out_valid", out_valid, model_ov());
    if (model_ov()) begin
      chk("out_result", out_result, exp_q[0][63:0]);
      chk("out_flags", out_flags, exp_q[0][66:64]);
    end
`ifdef FP_ROUND_STICKY_FLAGS_EN
    chk("sticky", sticky_flags, sticky_m);
`else
    chk("sticky_off", sticky_flags, 3'b0);
`endif
  endtask

  // One clock: drive at negedge, predict handshake, advance model at posedge, check at next negedge.
  task automatic step(input bit v, input bit s, input logic [11:0] e, input logic [55:0] mn,
                      input bit ssl, input logic [1:0] rm, input bit ordy, input bit clr);
    bit ir, ifire, ofire;
    logic [66:0] item;
    in_valid = v; in_sign = s; in_exp = e; in_mant = mn; in_second_shift = ssl; in_rm = rm;
    out_ready = ordy; flag_clr = clr;
    #1;
    ir = exp_q.size() < 2 || ordy;
    chk("in_ready", in_ready, ir);
    ifire = v && ir;
    ofire = ordy && model_ov();
    item  = ref_model(s, e, mn, ssl, rm);
    @(posedge clk);
    cyc++;
    sticky_m = clr ? 3'b0 : sticky_m | (ofire ? exp_q[0][66:64] : 3'b0);
    if (ofire) begin
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
    end
    if (ifire) begin
      exp_q.push_back(item);
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic dir(input string tag, input bit s, input logic [11:0] e, input logic [55:0] mn,
                     input bit ssl, input logic [1:0] rm, input logic [63:0] er, input logic [2:0] ef);
    step(1, s, e, mn, ssl, rm, 1, 0);
    chk({tag, "_lat1"}, out_valid, 1'b0);
    step(0, 0, '0, '0, 0, 0, 1, 0);
    chk({tag, "_lat2"}, out_valid, 1'b1);
    chk({tag, "_res"}, out_result, er);
    chk({tag, "_flg"}, out_flags, ef);
    step(0, 0, '0, '0, 0, 0, 1, 0);
  endtask

  localparam logic [55:0] ONE  = 56'h80_0000_0000_0000;
  localparam logic [55:0] ALL1 = 56'hFF_FFFF_FFFF_FFFC;

  initial begin
    logic [55:0] rm_mant;
    logic [11:0] rexp;
    int sel;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_result", out_result, 64'h0);
    chk("rst_flags", out_flags, 3'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sticky", sticky_flags, 3'b0);
    rst_n = 1;
    dir("t1_one", 0, 12'd1023, ONE, 0, 2'b00, 64'h3FF0000000000000, 3'b000);
    dir("t2_ssl", 0, 12'd1024, ONE, 1, 2'b00, 64'h3FF0000000000000, 3'b000);
    dir("t3_carry", 0, 12'd1023, ALL1, 0, 2'b00, 64'h4000000000000000, 3'b001);
    dir("t4_ovf_rne", 0, 12'd2046, ALL1, 0, 2'b00, 64'h7FF0000000000000, 3'b101);
    dir("t4_rtz", 0, 12'd2046, ALL1, 0, 2'b01, 64'h7FEFFFFFFFFFFFFF, 3'b001);
    dir("t4_ovf_rdn_pos", 0, 12'd2047, ONE, 0, 2'b11, 64'h7FEFFFFFFFFFFFFF, 3'b101);
    dir("t4_ovf_rdn_neg", 1, 12'd2047, ONE | 56'h1, 0, 2'b11, 64'hFFF0000000000000, 3'b101);
    dir("t6_flush", 0, 12'd1, ONE, 1, 2'b00, 64'h0, 3'b011);
    dir("zero_neg", 1, 12'd500, 56'h0, 0, 2'b10, 64'h8000000000000000, 3'b000);
    step(0, 0, '0, '0, 0, 0, 1, 1);
    // four back-to-back offers against three stalled cycles
    step(1, 0, 12'd1000, ONE | 56'h11, 0, 2'b00, 0, 0);
    step(1, 1, 12'd1001, ONE | 56'h25, 0, 2'b01, 0, 0);
    chk("t5_in_ready_full", in_ready, 1'b0);
    step(1, 0, 12'd1002, ONE | 56'h3F, 0, 2'b10, 0, 0);
    step(1, 0, 12'd1002, ONE | 56'h3F, 0, 2'b10, 1, 0);
    step(1, 1, 12'd1003, ONE | 56'h47, 0, 2'b11, 1, 0);
    repeat (3) step(0, 0, '0, '0, 0, 0, 1, 0);
    chk("t5_drained", exp_q.size(), 0);
    // reset with both stages full
    step(1, 0, 12'd700, ONE, 0, 2'b00, 0, 0);
    step(1, 0, 12'd701, ONE, 0, 2'b00, 0, 0);
    rst_n = 0; in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    exp_q.delete(); acc_q.delete(); sticky_m = '0; cyc++;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_in_ready", in_ready, 1'b1);
    repeat (2) step(0, 0, '0, '0, 0, 0, 1, 0);
    // sticky accumulate then clear
    dir("t6_flush2", 1, 12'd1, ONE, 1, 2'b00, 64'h8000000000000000, 3'b011);
    dir("t6_ovf", 0, 12'd2047, ONE, 0, 2'b00, 64'h7FF0000000000000, 3'b101);
`ifdef FP_ROUND_STICKY_FLAGS_EN
    chk("t6_sticky_acc", sticky_flags, 3'b111);
`endif
    step(0, 0, '0, '0, 0, 0, 1, 1);
    chk("t6_sticky_clr", sticky_flags, 3'b000);
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: rexp = 12'($urandom_range(0, 5)) - 12'd2;
        1: rexp = 12'($urandom_range(2043, 2047));
        2: rexp = 12'($urandom_range(1, 2046));
        default: rexp = 12'($urandom_range(2049, 4095));
      endcase
      rm_mant = {$urandom, $urandom};
      sel = int'($urandom_range(0, 15));
      if (sel == 0) rm_mant = '0;
      else if (sel < 5) rm_mant = {53'h1F_FFFF_FFFF_FFFF, rm_mant[2:0]};
      else rm_mant[55] = 1'b1;
      step($urandom_range(0, 3) != 0, 1'($urandom), rexp, rm_mant, 1'($urandom), 2'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    repeat (4) step(0, 0, '0, '0, 0, 0, 1, 0);
    chk("rand_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
